// File: rtl/core_pkg.sv
// Shared constants for the 5-stage MIPS core pipeline control.
// Muldiv FSM encoding and the decoder's mult/div opcode map.
package core_pkg;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  function automatic logic is_muldiv(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == OP_SPECIAL) &&
           (fn == FN_MULT || fn == FN_MULTU ||
            fn == FN_DIV  || fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in,
// stall/flush controls and muldiv status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic [4:0]       ex_rt;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_muldiv_start;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             muldiv_busy;
  logic             muldiv_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump,
    output ex_rt, ex_mem_read, ex_branch_taken,
    output ex_muldiv_start,
    input  pc_stall, if_id_stall, if_id_flush,
    input  id_ex_stall, id_ex_flush,
    input  muldiv_busy, muldiv_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump,
    input  ex_rt, ex_mem_read, ex_branch_taken,
    input  ex_muldiv_start,
    output pc_stall, if_id_stall, if_id_flush,
    output id_ex_stall, id_ex_flush,
    output muldiv_busy, muldiv_done, stall_cycles
  );

endinterface

// File: rtl/muldiv_seq.sv
// Mult/div occupancy sequencer: MULDIV_CYCLES-1 BUSY
// cycles then one DONE cycle per accepted start.
module muldiv_seq #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  import core_pkg::*;

  localparam int CW = $clog2(MULDIV_CYCLES);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= CW'(MULDIV_CYCLES - 2);
          end
        end
        MD_BUSY: begin
          if (cnt == '0) state <= MD_DONE;
          else cnt <= cnt - CW'(1);
        end
        // the muldiv op is still in EX here
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush for
// PC, IF/ID and ID/EX plus a saturating stall counter.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave hc
);

  import core_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic busy;
  logic done;
  logic lu;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic [CNT_W-1:0] stall_cnt;

  muldiv_seq #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_seq (
    .clock (clock),
    .reset (reset),
    .start (hc.ex_muldiv_start),
    .busy  (busy),
    .done  (done)
  );

  assign lu = hc.ex_mem_read &&
              (hc.ex_rt != REG_ZERO) &&
              ((hc.ex_rt == hc.id_rs) ||
               (hc.id_uses_rt && hc.ex_rt == hc.id_rt));

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    if (reset) begin
      pc_stall = 1'b0;
    end else if (busy) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
    end else if (hc.ex_branch_taken) begin
      // lu and jump sit on the wrong path
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hc.id_jump) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt <= '0;
    else if (pc_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

  assign hc.pc_stall     = pc_stall;
  assign hc.if_id_stall  = if_id_stall;
  assign hc.if_id_flush  = if_id_flush;
  assign hc.id_ex_stall  = id_ex_stall;
  assign hc.id_ex_flush  = id_ex_flush;
  assign hc.muldiv_busy  = busy;
  assign hc.muldiv_done  = done;
  assign hc.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random
// traffic against a cycle-age reference model.
module tb_hazard_ctrl;

  localparam int MC    = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int   age = 0;
  int   scnt = 0;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(
    .MULDIV_CYCLES(MC),
    .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hc    (hif.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic urt,
                       input logic jmp,
                       input logic [4:0] ert,
                       input logic mr,
                       input logic br,
                       input logic md);
    hif.id_rs           = rs;
    hif.id_rt           = rt;
    hif.id_uses_rt      = urt;
    hif.id_jump         = jmp;
    hif.ex_rt           = ert;
    hif.ex_mem_read     = mr;
    hif.ex_branch_taken = br;
    hif.ex_muldiv_start = md;
  endtask

  // check one cycle at negedge, then advance the model
  task automatic step();
    bit m_busy, m_done, m_lu;
    bit e_ps, e_ifs, e_iff, e_ies, e_ief;
    @(negedge clock);
    m_busy = (age >= 1) && (age <= MC - 1);
    m_done = (age == MC);
    m_lu = hif.ex_mem_read && hif.ex_rt != 0 &&
           (hif.ex_rt == hif.id_rs ||
            (hif.id_uses_rt && hif.ex_rt == hif.id_rt));
    {e_ps, e_ifs, e_iff, e_ies, e_ief} = 5'b00000;
    if (reset) ;
    else if (m_busy) {e_ps, e_ifs, e_ies} = 3'b111;
    else if (hif.ex_branch_taken) {e_iff, e_ief} = 2'b11;
    else if (m_lu) {e_ps, e_ifs, e_ief} = 3'b111;
    else if (hif.id_jump) e_iff = 1'b1;
    chk("pc_stall", 32'(hif.pc_stall), 32'(e_ps));
    chk("if_id_stall", 32'(hif.if_id_stall), 32'(e_ifs));
    chk("if_id_flush", 32'(hif.if_id_flush), 32'(e_iff));
    chk("id_ex_stall", 32'(hif.id_ex_stall), 32'(e_ies));
    chk("id_ex_flush", 32'(hif.id_ex_flush), 32'(e_ief));
    chk("muldiv_busy", 32'(hif.muldiv_busy), 32'(m_busy));
    chk("muldiv_done", 32'(hif.muldiv_done), 32'(m_done));
    chk("stall_cycles", 32'(hif.stall_cycles), 32'(scnt));
    @(posedge clock);
    if (reset) begin
      age  = 0;
      scnt = 0;
    end else begin
      if (age == 0) age = hif.ex_muldiv_start ? 1 : 0;
      else if (age < MC) age = age + 1;
      else age = 0;
      if (e_ps && scnt < CMAX) scnt = scnt + 1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    // load-use on rs, then same with ex_rt = $zero
    drive(8, 0, 0, 0, 8, 1, 0, 0);
    step();
    chk("lu_rs_pc", 32'(hif.stall_cycles), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step();

    // rt only matters when the ID op reads it
    drive(9, 8, 0, 0, 8, 1, 0, 0);
    step();
    drive(9, 8, 1, 0, 8, 1, 0, 0);
    step();

    // branch overrides lu and jump
    drive(8, 8, 1, 1, 8, 1, 1, 0);
    step();

    // jump deferred behind lu, then taken
    drive(8, 0, 0, 1, 8, 1, 0, 0);
    step();
    drive(8, 0, 0, 1, 8, 0, 0, 0);
    step();

    // muldiv with start held through BUSY
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("md_stall_cycles", 32'(hif.stall_cycles), 32'd3);

    // reset on the 2nd BUSY cycle aborts the op
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    chk("abort_busy", 32'(hif.muldiv_busy), 32'd0);
    chk("abort_cnt", 32'(hif.stall_cycles), 32'd0);

    // counter saturation
    drive(8, 0, 0, 0, 8, 1, 0, 0);
    for (int i = 0; i < CMAX; i++) step();
    chk("sat_full", 32'(hif.stall_cycles), 32'hFFFF);
    step();
    chk("sat_hold", 32'(hif.stall_cycles), 32'hFFFF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom),
            ($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 3)),
            1'($urandom),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage MIPS core.
- Generates the stall and flush controls for PC, IF/ID and ID/EX pipeline registers from:
  - load-use dependencies
  - taken branches resolved in EX
  - jumps decoded in ID
  - a multi-cycle multiply/divide unit sequenced by an internal FSM.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MULDIV_CYCLES, 4, EX occupancy of mult/div in cycles (legal range 2..32)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  ID instruction is j/jal/jr (redirect from ID)
ex_rt  in  5  rt of instruction in EX
ex_mem_read  in  1  EX instruction is a load (reg_src=1)
ex_branch_taken  in  1  branch in EX resolved taken
ex_muldiv_start  in  1  EX instruction is mult/multu/div/divu
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  zero IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  zero ID/EX (bubble)
muldiv_busy  out  1  FSM in BUSY
muldiv_done  out  1  FSM in DONE (result valid to hi/lo write)
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock port is clock; reset port is reset, synchronous, active-high. One clock domain.
- Control outputs (stall/flush) are combinational from FSM state and inputs, with zero latency: they act at the same edge the pipe registers sample.
- FSM states: IDLE, BUSY, DONE. The counter cnt is clog2(MULDIV_CYCLES) bits wide.
  - IDLE: if ex_muldiv_start=1, go to BUSY and set cnt=MULDIV_CYCLES-2.
  - BUSY: if cnt==0, go to DONE; else cnt decrements.
  - DONE: go to IDLE unconditionally. ex_muldiv_start is ignored in DONE, because the same instruction is still in EX.
  - Result: exactly MULDIV_CYCLES-1 BUSY cycles followed by 1 DONE cycle.
- Load-use condition lu:
  - lu = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Output priority, highest first:
  1. BUSY: pc_stall=if_id_stall=id_ex_stall=1; all flushes 0. lu and id_jump are ignored; ex_branch_taken cannot occur because EX holds the muldiv instruction.
  2. ex_branch_taken: if_id_flush=id_ex_flush=1; all stalls 0. This overrides lu and id_jump, which belong to the wrong path.
  3. lu: pc_stall=if_id_stall=1, id_ex_flush=1; id_ex_stall=0. id_jump is deferred; it re-evaluates next cycle.
  4. id_jump: if_id_flush=1 only.
  5. Otherwise all controls are 0.
- Invariants:
  - Never assert x_stall and x_flush together for the same register.
  - IDLE and DONE are transparent to priorities 2-5.
- muldiv_busy=1 iff state==BUSY; muldiv_done=1 iff state==DONE.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).
- Reset:
  - state=IDLE, cnt=0, stall_cycles=0.
  - With all inputs 0, every output is 0.
  - Reset during BUSY aborts the operation: IDLE next cycle, stalls drop immediately when reset is sampled.
- Back-to-back muldiv: after DONE the next instruction enters EX, and its start is accepted in IDLE the following cycle.

Decomposition:
- Shared package core_pkg holds:
  - the FSM state encoding localparams (MD_IDLE, MD_BUSY, MD_DONE)
  - REG_ZERO=5'd0
  - the muldiv opcode/funct constants used by the decoder to form ex_muldiv_start.
- One natural sub-module, muldiv_seq: the FSM plus cnt, outputs busy/done.
- Priority logic and the perf counter stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_stall=if_id_stall=id_ex_flush=1, id_ex_stall=0. With ex_rt=0, same stimulus -> all outputs 0.
- id_uses_rt=0, id_rt=8, ex_rt=8, ex_mem_read=1, id_rs=9 -> no stall. Set id_uses_rt=1 -> stall asserted.
- ex_muldiv_start=1 held, MULDIV_CYCLES=4 -> muldiv_busy=1 for cycles 1-3, muldiv_done at cycle 4 with stalls 0, IDLE at cycle 5. stall_cycles=3.
- ex_branch_taken=1 with lu=1 and id_jump=1 same cycle -> if_id_flush=id_ex_flush=1, all stalls 0.
- id_jump=1 during lu -> only lu response. id_jump=1 next cycle with lu=0 -> if_id_flush=1.
- Assert reset at 2nd BUSY cycle -> next cycle state IDLE, all stalls 0, stall_cycles=0. Separately preload 2^CNT_W-1 stall cycles, stall once more -> stall_cycles stays 16'hFFFF.
